// File: rtl/inc_stream_check.sv
// inc_stream_check: checks that valid samples form a +1 (mod 256) stream, locks after a clean run, counts sequence errors
module inc_stream_check #(
  parameter int P_DELAY    = 1,
  parameter int P_LOCK_CNT = 4
) (
  input  logic        CLK_I,
  input  logic        RST_X,
  input  logic [7:0]  DATA_I,
  input  logic        VALID_I,
  input  logic        CLR_I,
  output logic        LOCKED_O,
  output logic        ERR_O,
  output logic [15:0] ERR_CNT_O,
  output logic [7:0]  EXP_O
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;
  localparam logic [3:0] LOCK_RUN = 4'(P_LOCK_CNT);
  localparam int unused_delay = P_DELAY;
  state_t state;
  logic [3:0] run;
  logic [3:0] run_inc;
  logic [7:0] nxt;
  logic hit;
  assign run_inc = run + 4'd1;
  assign nxt = DATA_I + 8'd1;
  assign hit = DATA_I == EXP_O;
  // sequence FSM with registered outputs; a clear always wins over an error increment on the same edge
  always_ff @(posedge CLK_I) begin
    if (!RST_X) begin
      state     <= IDLE;
      run       <= 4'd0;
      LOCKED_O  <= 1'b0;
      ERR_O     <= 1'b0;
      ERR_CNT_O <= 16'h0000;
      EXP_O     <= 8'h00;
    end else begin
      ERR_O <= 1'b0;
      if (VALID_I) begin
        EXP_O <= nxt;
        case (state)
          IDLE: begin
            run   <= 4'd0;
            state <= ACQ;
          end
          ACQ: begin
            if (hit && run_inc == LOCK_RUN) begin
              run      <= 4'd0;
              state    <= LOCK;
              LOCKED_O <= 1'b1;
            end else begin
              run <= hit ? run_inc : 4'd0;
            end
          end
          LOCK: begin
            if (!hit) begin
              ERR_O     <= 1'b1;
              run       <= 4'd0;
              state     <= ACQ;
              LOCKED_O  <= 1'b0;
              ERR_CNT_O <= (ERR_CNT_O == 16'hFFFF) ? ERR_CNT_O : ERR_CNT_O + 16'd1;
            end
          end
          default: begin
            run      <= 4'd0;
            state    <= IDLE;
            LOCKED_O <= 1'b0;
          end
        endcase
      end
      if (CLR_I) ERR_CNT_O <= 16'h0000;
    end
  end
endmodule

// File: tb/tb_inc_stream_check.sv
// tb_inc_stream_check: table-driven and directed checks of inc_stream_check
module tb_inc_stream_check;
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  logic valid = 1'b0;
  logic clr = 1'b0;
  logic [7:0] data = 8'h00;
  logic locked, err, locked1, err1;
  logic [15:0] cnt, cnt1;
  logic [7:0] exp_o, exp1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  inc_stream_check dut (
    .CLK_I(clk), .RST_X(rst_x), .DATA_I(data), .VALID_I(valid), .CLR_I(clr),
    .LOCKED_O(locked), .ERR_O(err), .ERR_CNT_O(cnt), .EXP_O(exp_o)
  );
  inc_stream_check #(.P_LOCK_CNT(1)) dut1 (
    .CLK_I(clk), .RST_X(rst_x), .DATA_I(data), .VALID_I(valid), .CLR_I(clr),
    .LOCKED_O(locked1), .ERR_O(err1), .ERR_CNT_O(cnt1), .EXP_O(exp1)
  );
  typedef struct {
    logic r;
    logic v;
    logic [7:0] d;
    logic c;
    logic lk;
    logic er;
    logic [15:0] cn;
    logic [7:0] ex;
  } vec_t;
  vec_t tbl[46];
  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic c,
                              input logic lk, input logic er, input logic [15:0] cn, input logic [7:0] ex);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.c = c; t.lk = lk; t.er = er; t.cn = cn; t.ex = ex;
    return t;
  endfunction
  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic c);
    rst_x = r; valid = v; data = d; clr = c;
    @(negedge clk);
  endtask
  task automatic check(input string nm, input logic lk, input logic er, input logic [15:0] cn, input logic [7:0] ex);
    tests++;
    if ({locked, err, cnt, exp_o} !== {lk, er, cn, ex}) begin
      fails++;
      $display("FAIL %s: got locked=%b err=%b cnt=%h exp=%h, want locked=%b err=%b cnt=%h exp=%h",
               nm, locked, err, cnt, exp_o, lk, er, cn, ex);
    end
  endtask
  task automatic check1(input string nm, input logic lk, input logic [7:0] ex);
    tests++;
    if ({locked1, err1, exp1} !== {lk, 1'b0, ex}) begin
      fails++;
      $display("FAIL %s: got locked=%b err=%b exp=%h, want locked=%b err=0 exp=%h", nm, locked1, err1, exp1, lk, ex);
    end
  endtask
  initial begin
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 0, 16'h0, 8'h00);
    tbl[1]  = mk(1, 1, 8'h10, 0, 0, 0, 16'h0, 8'h11);
    tbl[2]  = mk(1, 1, 8'h11, 0, 0, 0, 16'h0, 8'h12);
    tbl[3]  = mk(1, 1, 8'h12, 0, 0, 0, 16'h0, 8'h13);
    tbl[4]  = mk(1, 1, 8'h13, 0, 0, 0, 16'h0, 8'h14);
    tbl[5]  = mk(1, 1, 8'h14, 0, 1, 0, 16'h0, 8'h15);
    tbl[6]  = mk(1, 1, 8'hF9, 0, 0, 1, 16'h1, 8'hFA);
    tbl[7]  = mk(1, 1, 8'hFA, 0, 0, 0, 16'h1, 8'hFB);
    tbl[8]  = mk(1, 1, 8'hFB, 0, 0, 0, 16'h1, 8'hFC);
    tbl[9]  = mk(1, 1, 8'hFC, 0, 0, 0, 16'h1, 8'hFD);
    tbl[10] = mk(1, 1, 8'hFD, 0, 1, 0, 16'h1, 8'hFE);
    tbl[11] = mk(1, 1, 8'hFE, 0, 1, 0, 16'h1, 8'hFF);
    tbl[12] = mk(1, 1, 8'hFF, 0, 1, 0, 16'h1, 8'h00);
    tbl[13] = mk(1, 1, 8'h00, 0, 1, 0, 16'h1, 8'h01);
    tbl[14] = mk(1, 1, 8'h01, 0, 1, 0, 16'h1, 8'h02);
    tbl[15] = mk(0, 1, 8'h1B, 1, 0, 0, 16'h0, 8'h00);
    tbl[16] = mk(1, 1, 8'h1B, 0, 0, 0, 16'h0, 8'h1C);
    tbl[17] = mk(1, 1, 8'h1C, 0, 0, 0, 16'h0, 8'h1D);
    tbl[18] = mk(1, 1, 8'h1D, 0, 0, 0, 16'h0, 8'h1E);
    tbl[19] = mk(1, 1, 8'h1E, 0, 0, 0, 16'h0, 8'h1F);
    tbl[20] = mk(1, 1, 8'h1F, 0, 1, 0, 16'h0, 8'h20);
    tbl[21] = mk(1, 1, 8'h25, 0, 0, 1, 16'h1, 8'h26);
    tbl[22] = mk(1, 1, 8'h26, 0, 0, 0, 16'h1, 8'h27);
    tbl[23] = mk(1, 1, 8'h50, 0, 0, 0, 16'h1, 8'h51);
    tbl[24] = mk(1, 1, 8'h51, 0, 0, 0, 16'h1, 8'h52);
    tbl[25] = mk(1, 1, 8'h52, 0, 0, 0, 16'h1, 8'h53);
    tbl[26] = mk(1, 0, 8'h77, 0, 0, 0, 16'h1, 8'h53);
    tbl[27] = mk(1, 1, 8'h53, 0, 0, 0, 16'h1, 8'h54);
    tbl[28] = mk(1, 1, 8'h54, 0, 1, 0, 16'h1, 8'h55);
    tbl[29] = mk(1, 1, 8'h55, 0, 1, 0, 16'h1, 8'h56);
    tbl[30] = mk(1, 0, 8'h00, 0, 1, 0, 16'h1, 8'h56);
    tbl[31] = mk(1, 0, 8'h99, 0, 1, 0, 16'h1, 8'h56);
    tbl[32] = mk(1, 0, 8'h00, 0, 1, 0, 16'h1, 8'h56);
    tbl[33] = mk(1, 1, 8'h56, 0, 1, 0, 16'h1, 8'h57);
    tbl[34] = mk(1, 0, 8'h00, 1, 1, 0, 16'h0, 8'h57);
    tbl[35] = mk(1, 1, 8'h60, 1, 0, 1, 16'h0, 8'h61);
    tbl[36] = mk(1, 1, 8'h61, 0, 0, 0, 16'h0, 8'h62);
    tbl[37] = mk(1, 1, 8'h62, 0, 0, 0, 16'h0, 8'h63);
    tbl[38] = mk(1, 1, 8'h63, 0, 0, 0, 16'h0, 8'h64);
    tbl[39] = mk(1, 1, 8'h64, 0, 1, 0, 16'h0, 8'h65);
    tbl[40] = mk(0, 1, 8'h65, 0, 0, 0, 16'h0, 8'h00);
    tbl[41] = mk(1, 1, 8'h55, 0, 0, 0, 16'h0, 8'h56);
    tbl[42] = mk(1, 1, 8'h56, 0, 0, 0, 16'h0, 8'h57);
    tbl[43] = mk(1, 1, 8'h57, 0, 0, 0, 16'h0, 8'h58);
    tbl[44] = mk(1, 1, 8'h58, 0, 0, 0, 16'h0, 8'h59);
    tbl[45] = mk(1, 1, 8'h59, 0, 1, 0, 16'h0, 8'h5A);
    for (int i = 0; i < 46; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].cn, tbl[i].ex);
    end
    drive(0, 0, 8'h00, 0);
    check("reset2", 0, 0, 16'h0, 8'h00);
    check1("lock1_reset", 0, 8'h00);
    drive(1, 1, 8'h70, 0);
    check1("lock1_idle", 0, 8'h71);
    drive(1, 1, 8'h71, 0);
    check1("lock1_first_match", 1, 8'h72);
    check("lock4_not_yet", 0, 0, 16'h0, 8'h72);
    for (int k = 8'h72; k <= 8'h74; k++) drive(1, 1, 8'(k), 0);
    check("lock4_relock", 1, 0, 16'h0, 8'h75);
    force dut.ERR_CNT_O = 16'hFFFD;
    #1;
    release dut.ERR_CNT_O;
    drive(1, 1, 8'h00, 0);
    check("sat_fffe", 0, 1, 16'hFFFE, 8'h01);
    for (int k = 1; k <= 4; k++) drive(1, 1, 8'(k), 0);
    check("sat_relock1", 1, 0, 16'hFFFE, 8'h05);
    drive(1, 1, 8'h00, 0);
    check("sat_ffff", 0, 1, 16'hFFFF, 8'h01);
    for (int k = 1; k <= 4; k++) drive(1, 1, 8'(k), 0);
    check("sat_relock2", 1, 0, 16'hFFFF, 8'h05);
    drive(1, 1, 8'h00, 0);
    check("sat_hold", 0, 1, 16'hFFFF, 8'h01);
    drive(1, 0, 8'h00, 0);
    check("err_one_cycle", 0, 0, 16'hFFFF, 8'h01);
    for (int k = 1; k <= 4; k++) drive(1, 1, 8'(k), 0);
    check("sat_relock3", 1, 0, 16'hFFFF, 8'h05);
    drive(1, 1, 8'h00, 1);
    check("clr_collide", 0, 1, 16'h0, 8'h01);
    drive(1, 0, 8'h00, 0);
    check("after_collide", 0, 0, 16'h0, 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inc_stream_check.md
INC_STREAM_CHECK -- requirements
Module: inc_stream_check

Interface
REQ-001 SHALL have parameter P_DELAY, default 1, simulation-only delay applied to every register update; no effect on cycle behaviour.
REQ-002 SHALL have parameter P_LOCK_CNT, default 4, legal range 1..15: the number of consecutive matching samples in ACQ needed to enter LOCK.
REQ-003 CLK_I  input  1  the single clock; all state updates on the rising edge.
REQ-004 RST_X  input  1  reset, synchronous and active-low, sampled on the CLK_I rising edge.
REQ-005 DATA_I  input  8  incoming increment-stream sample, synchronous to CLK_I.
REQ-006 VALID_I  input  1  DATA_I qualifier; a sample is consumed only on an edge where VALID_I=1.
REQ-007 CLR_I  input  1  synchronous clear of ERR_CNT_O.
REQ-008 LOCKED_O  output  1  registered, high while the state is LOCK.
REQ-009 ERR_O  output  1  registered one-cycle pulse per sequence error detected in LOCK.
REQ-010 ERR_CNT_O  output  16  registered, saturating count of errors.
REQ-011 EXP_O  output  8  registered, next expected sample value.

Function
REQ-012 SHALL check that consecutive valid samples follow next = previous + 1 modulo 256; 8'hFF followed by 8'h00 is a match.
REQ-013 SHALL implement states IDLE, ACQ and LOCK, plus a 4-bit run counter RUN.
REQ-014 IDLE, valid sample: EXP <= DATA_I+1, RUN <= 0, go to ACQ; no error.
REQ-015 ACQ, valid sample equal to EXP: EXP <= DATA_I+1 and RUN <= RUN+1; if RUN+1 == P_LOCK_CNT, go to LOCK and clear RUN.
REQ-016 ACQ, valid sample not equal to EXP: EXP <= DATA_I+1, RUN <= 0, stay in ACQ; no ERR_O and no count.
REQ-017 LOCK, valid sample equal to EXP: EXP <= DATA_I+1, stay in LOCK.
REQ-018 LOCK, valid sample not equal to EXP:
  - ERR_O = 1 for exactly the next cycle.
  - ERR_CNT_O increments.
  - EXP <= DATA_I+1, RUN <= 0.
  - go to ACQ (resynchronise on the bad sample).
REQ-019 VALID_I=0: state, RUN, EXP and ERR_CNT_O SHALL hold, and ERR_O SHALL be 0 on the next cycle; gaps in VALID_I never count as errors.
REQ-020 Latency: all outputs SHALL reflect a consumed sample on the cycle after the sampling edge; no combinational input-to-output paths.
REQ-021 ERR_CNT_O SHALL saturate at 16'hFFFF; further errors still pulse ERR_O.
REQ-022 CLR_I=1 SHALL set ERR_CNT_O to 0 on the next cycle; if an error occurs on the same edge, the clear wins (count 0) and ERR_O still pulses.
REQ-023 CLR_I SHALL NOT affect state, RUN, EXP or LOCKED_O.
REQ-024 With P_LOCK_CNT=1, the first matching sample in ACQ SHALL enter LOCK.

Reset
REQ-025 On an edge with RST_X=0, the block SHALL go to IDLE with RUN=0, and all outputs SHALL become zero: LOCKED_O=0, ERR_O=0, ERR_CNT_O=16'h0000, EXP_O=8'h00.
REQ-026 Reset SHALL override VALID_I and CLR_I, including mid-acquisition and in LOCK; the first valid sample after reset is treated as in IDLE.

Verification
REQ-027 Lock-up, P_LOCK_CNT=4: valid 10,11,12,13,14 on consecutive cycles -> LOCKED_O rises the cycle after sample 14; EXP_O=15; ERR_CNT_O=0.
REQ-028 Wrap-around: while locked, feed FE,FF,00,01 -> no ERR_O, LOCKED_O stays 1, EXP_O=02.
REQ-029 Error and resync: locked with EXP=20, feed 25 -> ERR_O pulses one cycle, ERR_CNT_O=1, LOCKED_O=0, EXP_O=26; then 26,27,28,29 -> relock.
REQ-030 Valid gaps: locked, feed 30, VALID_I low 3 cycles, then 31 -> no error, LOCKED_O stays 1.
REQ-031 Clear collision: force ERR_CNT_O=16'hFFFF via repeated errors (saturation, no wrap); then mismatch together with CLR_I=1 -> ERR_O=1, ERR_CNT_O=0.
REQ-032 Reset mid-lock: locked, with RST_X=0 for one edge -> all outputs 0, state IDLE; the next valid 55 then needs P_LOCK_CNT further matches to lock.
